// File: rtl/pipe_control.sv
// Pipeline hazard/control unit for a Y86-style five-stage pipeline.
// Detects load-use, branch mispredict, ret and exception hazards and produces
// stall/bubble controls for the F, D, E, M and W pipeline registers.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_control #(
    parameter int RET_DEPTH = 3
) (
    input  logic        clk,
    input  logic        res,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  E_dstM,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic        e_Cnd,
    input  logic [2:0]  m_stat,
    input  logic [2:0]  W_stat,
    output logic        F_stall,
    output logic        D_stall,
    output logic        W_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        M_bubble,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt,
`endif
    output logic        halted
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_RET_WAIT = 2'd1;
    localparam logic [1:0] ST_HALTED   = 2'd2;

    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [2:0] S_AOK    = 3'd1;

    localparam logic [2:0] RET_INIT = 3'(RET_DEPTH - 1);
    localparam bit         RET_MULTI = (RET_DEPTH > 1);

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic load_use, mispredict, ret_take, exc_m, exc_w;
    logic d_stall_req, d_bubble_req;

    // M_icode is part of the pipeline-register view but no hazard depends on it.
    logic unused_inputs;
    assign unused_inputs = ^M_icode;

    // Hazard conditions decoded from the pipeline registers.
    always_comb begin
        load_use   = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != R_NONE) &&
                     ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mispredict = (E_icode == I_JXX) && !e_Cnd;
        ret_take   = (D_icode == I_RET) && !load_use && !mispredict;
        exc_m      = (m_stat != S_AOK);
        exc_w      = (W_stat != S_AOK);
    end

    // Stall/bubble outputs; reset flushes, HALTED freezes everything.
    always_comb begin
        F_stall      = 1'b0;
        D_stall      = 1'b0;
        W_stall      = 1'b0;
        D_bubble     = 1'b0;
        E_bubble     = 1'b0;
        M_bubble     = 1'b0;
        halted       = 1'b0;
        d_stall_req  = 1'b0;
        d_bubble_req = 1'b0;
        if (!res) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else if (state_q == ST_HALTED) begin
            F_stall = 1'b1;
            D_stall = 1'b1;
            W_stall = 1'b1;
            halted  = 1'b1;
        end else begin
            M_bubble = exc_m || exc_w;
            W_stall  = exc_w;
            if (state_q == ST_RET_WAIT) begin
                F_stall      = 1'b1;
                d_bubble_req = 1'b1;
            end else if (load_use) begin
                F_stall     = 1'b1;
                d_stall_req = 1'b1;
                E_bubble    = 1'b1;
            end else if (mispredict) begin
                d_bubble_req = 1'b1;
                E_bubble     = 1'b1;
            end else if (ret_take) begin
                F_stall      = 1'b1;
                d_bubble_req = 1'b1;
            end
            // A stalled D register must keep its instruction, so stall wins.
            D_stall  = d_stall_req;
            D_bubble = d_bubble_req && !d_stall_req;
        end
    end

    // Next-state logic; an exception in W overrides every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (exc_w) begin
            state_d = ST_HALTED;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ret_take && RET_MULTI) begin
                        state_d = ST_RET_WAIT;
                        cnt_d   = RET_INIT;
                    end
                end
                ST_RET_WAIT: begin
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                ST_HALTED: state_d = ST_HALTED;
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Performance counters: fetch-stall cycles outside HALTED, and bubble cycles.
    always_ff @(posedge clk) begin
        if (!res) begin
            stall_cnt  <= 32'd0;
            bubble_cnt <= 32'd0;
        end else begin
            if (F_stall && (state_q != ST_HALTED)) stall_cnt <= stall_cnt + 32'd1;
            if (D_bubble || E_bubble || M_bubble) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule
